// File: rtl/alu_nbit_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq_pkg
//  Purpose  : Shared definitions for the N-bit sequential ALU. It holds the
//             MIPS funct codes, the FSM state encoding and a legality helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_nbit_seq_pkg;

   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MULTU = 6'b011001;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   function automatic logic is_legal(input logic [5:0] func);
      return (func == F_AND) || (func == F_OR)  || (func == F_ADD) ||
             (func == F_SUB) || (func == F_SLT) || (func == F_SRL) ||
             (func == F_MULTU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_nbit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq_if
//  Purpose  : Request/result bundle between the EX-stage controller (master)
//             and the sequential ALU (slave).
//  Signals  : start, Signal, dataA, dataB   controller -> ALU
//             dataOut, dataHi, zero, overflow, illegal, valid, busy
//                                          ALU -> controller
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_nbit_seq_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [5:0]       Signal;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [WIDTH-1:0] dataOut;
   logic [WIDTH-1:0] dataHi;
   logic             zero;
   logic             overflow;
   logic             illegal;
   logic             valid;
   logic             busy;

   modport master (
      output start, Signal, dataA, dataB,
      input  dataOut, dataHi, zero, overflow, illegal, valid, busy
   );

   modport slave (
      input  start, Signal, dataA, dataB,
      output dataOut, dataHi, zero, overflow, illegal, valid, busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_nbit_comb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_comb
//  Purpose  : Combinational single-cycle ALU core: AND/OR/ADD/SUB/SLT/SRL
//             result, signed overflow and illegal-code detection. MULTU is
//             reported legal here; its result comes from the top's datapath.
//  Ports    : func     in  6      funct code
//             a, b     in  WIDTH  operands (SRL shift amount in b[SHW-1:0])
//             result   out WIDTH  single-cycle result
//             overflow out 1      signed overflow (ADD/SUB only)
//             illegal  out 1      func not in the opcode table
//  Revision : 1.0 - initial release
// ============================================================================
module alu_nbit_comb
   import alu_nbit_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             illegal
);
   localparam int SHW = $clog2(WIDTH);

   logic             w_sub_mode;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic             w_add_ovf;
   logic             w_lt;

   always_comb begin
      // SLT shares the subtractor; A + ~B + 1.
      w_sub_mode = (func == F_SUB) || (func == F_SLT);
      w_b_eff    = w_sub_mode ? ~b : b;
      w_sum      = a + w_b_eff + {{(WIDTH-1){1'b0}}, w_sub_mode};
      w_add_ovf  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      // Sign of the difference corrected by overflow gives the true signed compare.
      w_lt       = w_sum[WIDTH-1] ^ w_add_ovf;

      result   = '0;
      overflow = 1'b0;
      illegal  = ~is_legal(func);
      case (func)
         F_AND:   result = a & b;
         F_OR:    result = a | b;
         F_ADD,
         F_SUB: begin
            result   = w_sum;
            overflow = w_add_ovf;
         end
         F_SLT:   result = {{(WIDTH-1){1'b0}}, w_lt};
         F_SRL:   result = a >> b[SHW-1:0];
         default: result = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/alu_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_nbit_seq
//  Purpose  : N-bit registered ALU with start/valid handshake, zero/overflow/
//             illegal flags and a shift-add unsigned multiply (one multiplier
//             bit per clock, WIDTH cycles latency).
//  Ports    : clk    in  1   rising-edge clock
//             reset  in  1   asynchronous, active-low
//             bus    slave   start/Signal/dataA/dataB in;
//                            dataOut/dataHi/zero/overflow/illegal/valid/busy out
//  Revision : 1.0 - initial release
// ============================================================================
module alu_nbit_seq
   import alu_nbit_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   alu_nbit_seq_if.slave bus
);
   localparam int             SHW      = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   state_t             r_state;
   logic [SHW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_mcand;     // multiplicand, shifted left each step
   logic [WIDTH-1:0]   r_mplier;    // multiplier, shifted right each step
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_data_out;
   logic [WIDTH-1:0]   r_data_hi;
   logic               r_zero;
   logic               r_overflow;
   logic               r_illegal;
   logic               r_valid;

   logic [WIDTH-1:0]   w_res;
   logic               w_ovf;
   logic               w_ill;
   logic [2*WIDTH-1:0] w_acc_next;

   alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
      .func     (bus.Signal),
      .a        (bus.dataA),
      .b        (bus.dataB),
      .result   (w_res),
      .overflow (w_ovf),
      .illegal  (w_ill)
   );

   // Testing r_mplier[0] against a left-shifted multiplicand is the same as
   // testing B[cnt] and adding A<<cnt.
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
         r_data_out <= '0;
         r_data_hi  <= '0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_illegal  <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.Signal == F_MULTU) begin
                     r_mcand  <= {{WIDTH{1'b0}}, bus.dataA};
                     r_mplier <= bus.dataB;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_state  <= S_MUL;
                  end else begin
                     r_valid    <= 1'b1;
                     r_overflow <= w_ovf;
                     r_illegal  <= w_ill;
                     // An illegal code leaves the previous result visible.
                     if (!w_ill) begin
                        r_data_out <= w_res;
                        r_data_hi  <= '0;
                        r_zero     <= (w_res == '0);
                     end
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + SHW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state    <= S_IDLE;
                  r_valid    <= 1'b1;
                  r_data_out <= w_acc_next[WIDTH-1:0];
                  r_data_hi  <= w_acc_next[2*WIDTH-1:WIDTH];
                  r_zero     <= (w_acc_next[WIDTH-1:0] == '0);
                  r_overflow <= 1'b0;
                  r_illegal  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.dataOut  = r_data_out;
   assign bus.dataHi   = r_data_hi;
   assign bus.zero     = r_zero;
   assign bus.overflow = r_overflow;
   assign bus.illegal  = r_illegal;
   assign bus.valid    = r_valid;
   assign bus.busy     = (r_state == S_MUL);
endmodule
`default_nettype wire

// File: tb/tb_alu_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_nbit_seq
//  Purpose  : Directed self-checking bench for alu_nbit_seq at WIDTH=8 and 32.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_nbit_seq;
   import alu_nbit_seq_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n;
   int   vcount;

   alu_nbit_seq_if #(.WIDTH(8))  b8 ();
   alu_nbit_seq_if #(.WIDTH(32)) b32 ();

   alu_nbit_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));
   alu_nbit_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one start to the 8-bit DUT; returns 1 time unit after the sampling edge.
   task automatic op8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
      b8.start  = 1'b1;
      b8.Signal = f;
      b8.dataA  = a;
      b8.dataB  = b;
      tick();
      b8.start  = 1'b0;
   endtask

   initial begin
      b8.start = 1'b0;  b8.Signal = 6'd0;  b8.dataA = '0;  b8.dataB = '0;
      b32.start = 1'b0; b32.Signal = 6'd0; b32.dataA = '0; b32.dataB = '0;

      // ---- reset state ----
      repeat (2) tick();
      chk("rst_out",   b8.dataOut,  8'h00);
      chk("rst_hi",    b8.dataHi,   8'h00);
      chk("rst_flags", {b8.zero, b8.overflow, b8.illegal, b8.valid, b8.busy}, 5'b00000);
      reset = 1'b1;
      tick();

      // ---- ADD with signed overflow ----
      op8(F_ADD, 8'h7F, 8'h01);
      chk("add_out",   b8.dataOut, 8'h80);
      chk("add_flags", {b8.zero, b8.overflow, b8.illegal, b8.valid}, 4'b0101);
      tick();
      chk("add_vpulse", b8.valid, 1'b0);

      // ---- illegal code holds result ----
      op8(6'b111111, 8'h01, 8'h02);
      chk("ill_out",   b8.dataOut, 8'h80);
      chk("ill_flags", {b8.zero, b8.overflow, b8.illegal, b8.valid}, 4'b0011);

      // ---- SUB to zero, SLT with internal overflow ----
      op8(F_SUB, 8'h05, 8'h05);
      chk("sub_out",   b8.dataOut, 8'h00);
      chk("sub_flags", {b8.zero, b8.overflow, b8.illegal, b8.valid}, 4'b1001);
      op8(F_SLT, 8'h80, 8'h7F);
      chk("slt_lt",    b8.dataOut, 8'h01);
      chk("slt_ovf",   b8.overflow, 1'b0);
      op8(F_SLT, 8'h7F, 8'h80);
      chk("slt_ge",    b8.dataOut, 8'h00);
      op8(F_SUB, 8'h80, 8'h01);
      chk("sub_ovf",   {b8.dataOut, b8.overflow}, {8'h7F, 1'b1});

      // ---- back-to-back SRL / AND / OR ----
      vcount = 0;
      b8.start = 1'b1; b8.Signal = F_SRL; b8.dataA = 8'hF0; b8.dataB = 8'h04;
      tick(); vcount += int'(b8.valid);
      chk("srl_out", b8.dataOut, 8'h0F);
      b8.Signal = F_AND; b8.dataB = 8'h3C;
      tick(); vcount += int'(b8.valid);
      chk("and_out", b8.dataOut, 8'h30);
      b8.Signal = F_OR;
      tick(); vcount += int'(b8.valid);
      chk("or_out",  b8.dataOut, 8'hFC);
      b8.start = 1'b0;
      chk("b2b_valids", vcount, 3);
      op8(F_SRL, 8'hA5, 8'h08);
      chk("srl_zero_shamt", b8.dataOut, 8'hA5);

      // ---- MULTU 0xFF * 0xFF, start ignored while busy ----
      op8(F_OR, 8'hF0, 8'h0C);
      op8(F_MULTU, 8'hFF, 8'hFF);
      chk("mul_busy0", {b8.busy, b8.valid}, 2'b10);
      n = 0;
      while (b8.valid !== 1'b1 && n < 40) begin
         tick();
         n++;
         if (n == 2) begin
            b8.start = 1'b1; b8.Signal = F_ADD; b8.dataA = 8'h01; b8.dataB = 8'h01;
         end else begin
            b8.start = 1'b0;
         end
         if (n == 4) begin
            chk("mul_busy_mid", b8.busy, 1'b1);
            chk("mul_hold_out", b8.dataOut, 8'hFC);
         end
      end
      chk("mul_latency", n, 8);
      chk("mul_hi",    b8.dataHi,  8'hFE);
      chk("mul_lo",    b8.dataOut, 8'h01);
      chk("mul_flags", {b8.zero, b8.overflow, b8.illegal, b8.busy}, 4'b0000);
      // Next start accepted in the valid cycle; dataHi cleared by a legal op.
      op8(F_ADD, 8'h10, 8'h20);
      chk("post_mul_add", {b8.dataHi, b8.dataOut, b8.valid}, {8'h00, 8'h30, 1'b1});

      // ---- MULTU with zero low word ----
      op8(F_MULTU, 8'h10, 8'h10);
      n = 0;
      while (b8.valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("mul2_res",  {b8.dataHi, b8.dataOut, b8.zero}, {8'h01, 8'h00, 1'b1});

      // ---- reset mid-MULTU ----
      op8(F_ADD, 8'h11, 8'h22);
      op8(F_MULTU, 8'h0F, 8'h0F);
      repeat (3) tick();
      reset = 1'b0;
      #1;
      chk("arst_out",   {b8.dataHi, b8.dataOut}, 16'h0000);
      chk("arst_flags", {b8.zero, b8.overflow, b8.illegal, b8.valid, b8.busy}, 5'b00000);
      tick();
      reset = 1'b1;
      vcount = 0;
      repeat (10) begin
         tick();
         vcount += int'(b8.valid);
      end
      chk("arst_no_valid", vcount, 0);
      op8(F_ADD, 8'h03, 8'h04);
      chk("arst_add", {b8.dataOut, b8.valid, b8.busy}, {8'h07, 1'b1, 1'b0});

      // ---- WIDTH=32 ----
      b32.start = 1'b1; b32.Signal = F_ADD; b32.dataA = 32'h7FFF_FFFF; b32.dataB = 32'h1;
      tick();
      b32.start = 1'b0;
      chk("w32_add", {b32.dataOut, b32.overflow, b32.valid}, {32'h8000_0000, 1'b1, 1'b1});
      b32.start = 1'b1; b32.Signal = F_SRL; b32.dataA = 32'h8000_0000; b32.dataB = 32'h1F;
      tick();
      b32.start = 1'b0;
      chk("w32_srl", b32.dataOut, 32'h1);
      b32.start = 1'b1; b32.Signal = F_MULTU; b32.dataA = 32'hFFFF_FFFF; b32.dataB = 32'hFFFF_FFFF;
      tick();
      b32.start = 1'b0;
      n = 0;
      while (b32.valid !== 1'b1 && n < 80) begin
         tick();
         n++;
      end
      chk("w32_mul_latency", n, 32);
      chk("w32_mul", {b32.dataHi, b32.dataOut}, 64'hFFFF_FFFE_0000_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
